// File: rtl/lpc_sniffer_pkg.sv
// -----------------------------------------------------------------------------
// lpc_sniffer_pkg
// Shared definitions for the LPC capture path:
//   - LPC cycle type + direction encodings ({type[1:0], dir, 1'b0})
//   - record byte offsets that do not depend on the address width
//   - end-of-record marker byte
//   - record writer FSM states
//   - lpc_cycle_t: one captured LPC cycle (address held at full 32 bits)
// -----------------------------------------------------------------------------
package lpc_sniffer_pkg;

  localparam logic [3:0] CYC_IO_READ   = 4'h0;
  localparam logic [3:0] CYC_IO_WRITE  = 4'h2;
  localparam logic [3:0] CYC_MEM_READ  = 4'h4;
  localparam logic [3:0] CYC_MEM_WRITE = 4'h6;

  // Record layout: type byte first, address bytes follow MSB first.
  localparam int OFF_TYPE = 0;
  localparam int OFF_ADDR = 1;

  localparam logic [7:0] REC_MARKER = 8'h5A;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  typedef struct packed {
    logic [3:0]  cyctype_dir;
    logic [31:0] addr;
    logic [7:0]  data;
  } lpc_cycle_t;

endpackage

// File: rtl/lpc_record_writer_if.sv
// -----------------------------------------------------------------------------
// lpc_record_writer_if
// Bundles the decoded-LPC input side and the byte-wide capture RAM write side
// of lpc_record_writer.
//   lpc_cyctype_dir/lpc_addr/lpc_data/lpc_latch : decoded cycle + strobe
//   ram_addr/ram_data/ram_write                 : one byte written per cycle
// Modports:
//   master : LPC decoder side (drives the cycle, observes the RAM writes)
//   slave  : record writer (consumes the cycle, drives the RAM writes)
// -----------------------------------------------------------------------------
interface lpc_record_writer_if #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 8
);
  logic [3:0]        lpc_cyctype_dir;
  logic [ADDR_W-1:0] lpc_addr;
  logic [7:0]        lpc_data;
  logic              lpc_latch;

  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_write;

  modport master (
    output lpc_cyctype_dir, lpc_addr, lpc_data, lpc_latch,
    input  ram_addr, ram_data, ram_write
  );

  modport slave (
    input  lpc_cyctype_dir, lpc_addr, lpc_data, lpc_latch,
    output ram_addr, ram_data, ram_write
  );
endinterface

// File: rtl/lpc_capture_skid.sv
// -----------------------------------------------------------------------------
// lpc_capture_skid
// One-entry pending register for an LPC cycle that arrives while the writer
// is busy.
//   clock, reset_n : rising-edge clock, async active-low reset
//   push, push_cyc : offer a cycle; accepted if empty or being popped
//   pop            : writer consumes (or discards) the held cycle
//   valid, cyc     : held cycle
//   drop           : push refused because the entry is full and not popped
// -----------------------------------------------------------------------------
module lpc_capture_skid
  import lpc_sniffer_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  lpc_cycle_t push_cyc,
  input  logic       pop,
  output logic       valid,
  output lpc_cycle_t cyc,
  output logic       drop
);

  // A held cycle is never overwritten; the newcomer is the one lost.
  assign drop = push && valid && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      cyc   <= '0;
    end else if (push && (!valid || pop)) begin
      valid <= 1'b1;
      cyc   <= push_cyc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lpc_record_writer.sv
// -----------------------------------------------------------------------------
// lpc_record_writer
// Writes each captured LPC cycle as a 2^REC_AW byte record into a ring of
// slots in a byte-wide RAM, one byte per clock.
// Record: {4'h0,cyctype_dir}, address MSB first, data, drop count,
//         zero padding, 8'h5A marker in the last byte.
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus (slave)    : LPC cycle input + RAM write output (registered)
//   rd_slot        : consumer's next unread slot (sampled at record start)
//   wr_slot        : next slot to write; advances when a record completes
//   busy           : record in progress or cycle pending
//   overflow       : sticky, set on any dropped cycle
// -----------------------------------------------------------------------------
module lpc_record_writer
  import lpc_sniffer_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int RAM_AW = 8,
  parameter  int REC_AW = 3,
  localparam int SLOT_W = RAM_AW - REC_AW
) (
  input  logic               clock,
  input  logic               reset_n,
  lpc_record_writer_if.slave bus,
  input  logic [SLOT_W-1:0]  rd_slot,
  output logic [SLOT_W-1:0]  wr_slot,
  output logic               busy,
  output logic               overflow
);

  localparam int NB       = ADDR_W / 8;
  localparam int DATA_IDX = OFF_ADDR + NB;
  localparam int DROP_IDX = DATA_IDX + 1;
  localparam int LAST_IDX = (1 << REC_AW) - 1;
  localparam logic [REC_AW-1:0] LAST_BYTE = REC_AW'(LAST_IDX);

  function automatic logic [7:0] rec_byte(input lpc_cycle_t c,
                                          input logic [REC_AW-1:0] idx,
                                          input logic [7:0] drops);
    int i;
    i = int'(idx);
    if (i == OFF_TYPE)      return {4'h0, c.cyctype_dir};
    else if (i < DATA_IDX)  return c.addr[8*(NB-i) +: 8];
    else if (i == DATA_IDX) return c.data;
    else if (i == DROP_IDX) return drops;
    else if (i == LAST_IDX) return REC_MARKER;
    else                    return 8'h00;
  endfunction

  state_t            state_q, state_d;
  logic [REC_AW-1:0] byte_idx_q, byte_idx_nxt;
  logic [7:0]        drop_cnt_q;
  lpc_cycle_t        work_q, in_cyc, pend_cyc, src_cyc;
  logic              pend_valid, pend_pop, skid_push, skid_drop;
  logic              take_latch, src_drop, start, advance, commit;
  logic              ring_full, drop_evt;
  logic [SLOT_W-1:0] base_slot;

  // On the last byte the record is committed in the same edge, so any
  // back-to-back start must be placed (and full-checked) one slot further.
  assign commit       = (state_q == WRITE) && (byte_idx_q == LAST_BYTE);
  assign base_slot    = commit ? wr_slot + SLOT_W'(1) : wr_slot;
  assign ring_full    = (base_slot + SLOT_W'(1)) == rd_slot;
  assign byte_idx_nxt = byte_idx_q + REC_AW'(1);
  assign src_cyc      = pend_valid ? pend_cyc : in_cyc;
  assign skid_push    = bus.lpc_latch && !take_latch;
  assign drop_evt     = src_drop || skid_drop;
  assign busy         = (state_q == WRITE) || pend_valid;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_cyc                     = '0;
    in_cyc.cyctype_dir         = bus.lpc_cyctype_dir;
    in_cyc.addr[ADDR_W-1:0]    = bus.lpc_addr;
    in_cyc.data                = bus.lpc_data;
  end

  lpc_capture_skid u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (skid_push),
    .push_cyc (in_cyc),
    .pop      (pend_pop),
    .valid    (pend_valid),
    .cyc      (pend_cyc),
    .drop     (skid_drop)
  );

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    advance    = 1'b0;
    take_latch = 1'b0;
    src_drop   = 1'b0;
    pend_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        // Pending is older than a fresh strobe, so it goes first; the strobe
        // then refills the pending entry as it empties.
        if (pend_valid || bus.lpc_latch) begin
          take_latch = !pend_valid;
          pend_pop   = pend_valid;
          if (ring_full) begin
            src_drop = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (commit) begin
          if (pend_valid && !ring_full) begin
            start    = 1'b1;
            pend_pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          advance = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      byte_idx_q    <= '0;
      work_q        <= '0;
      wr_slot       <= '0;
      drop_cnt_q    <= '0;
      overflow      <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_data  <= '0;
      bus.ram_write <= 1'b0;
    end else begin
      state_q <= state_d;

      // RAM outputs are registered: byte 0 leaves on the edge that accepts
      // the cycle, giving a one-cycle strobe-to-write latency.
      if (start) begin
        work_q        <= src_cyc;
        byte_idx_q    <= '0;
        bus.ram_write <= 1'b1;
        bus.ram_addr  <= {base_slot, REC_AW'(0)};
        bus.ram_data  <= rec_byte(src_cyc, '0, drop_cnt_q);
      end else if (advance) begin
        byte_idx_q    <= byte_idx_nxt;
        bus.ram_addr  <= {wr_slot, byte_idx_nxt};
        bus.ram_data  <= rec_byte(work_q, byte_idx_nxt, drop_cnt_q);
      end else begin
        bus.ram_write <= 1'b0;
        byte_idx_q    <= '0;
      end

      if (commit) wr_slot <= base_slot;

      // Count restarts when it is copied into a record; a drop on that same
      // edge becomes the first drop of the next interval.
      if (advance && int'(byte_idx_nxt) == DROP_IDX)
        drop_cnt_q <= drop_evt ? 8'd1 : 8'd0;
      else if (drop_evt && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 8'd1;

      if (drop_evt) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lpc_record_writer.sv
// -----------------------------------------------------------------------------
// tb_lpc_record_writer
// Directed scenarios plus randomized traffic for lpc_record_writer. A
// transaction-level reference model (queue of record bytes, pending entry,
// drop counter, slot counter) predicts the RAM bus every cycle; a shadow RAM
// built from observed writes is also checked against literal record images.
// -----------------------------------------------------------------------------
module tb_lpc_record_writer;
  import lpc_sniffer_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int RAM_AW    = 8;
  localparam int REC_AW    = 3;
  localparam int SLOT_W    = RAM_AW - REC_AW;
  localparam int NB        = ADDR_W / 8;
  localparam int REC_BYTES = 1 << REC_AW;
  localparam int SLOTS     = 1 << SLOT_W;

  typedef struct {
    logic [3:0]  t;
    logic [31:0] a;
    logic [7:0]  d;
  } cyc_s;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b1;
  logic [SLOT_W-1:0] rd_slot;
  logic [SLOT_W-1:0] wr_slot;
  logic              busy;
  logic              overflow;

  lpc_record_writer_if #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) bus ();

  lpc_record_writer #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW), .REC_AW(REC_AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .rd_slot  (rd_slot),
    .wr_slot  (wr_slot),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] shadow [0:(1<<RAM_AW)-1];
  logic [7:0] exp_single [0:7] = '{8'h06, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hA5, 8'h00, 8'h5A};
  logic [3:0] cyc_tab [0:3]    = '{CYC_IO_READ, CYC_IO_WRITE, CYC_MEM_READ, CYC_MEM_WRITE};

  // ---------------- reference model ----------------
  int   rec_q[$];      // bytes of current record still to emit; -1 = drop count
  int   m_rec_slot, m_idx, m_slot, m_drops;
  bit   m_ovf, m_pend_v, exp_we;
  cyc_s m_pend;
  int   exp_addr, exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rec_q.delete();
    m_rec_slot = 0; m_idx = 0; m_slot = 0; m_drops = 0;
    m_ovf = 0; m_pend_v = 0; exp_we = 0; exp_addr = 0; exp_data = 0;
  endtask

  task automatic m_start(input cyc_s c, input int slot);
    rec_q.delete();
    rec_q.push_back(int'({4'h0, c.t}));
    for (int k = NB - 1; k >= 0; k--) rec_q.push_back(int'(c.a[8*k +: 8]));
    rec_q.push_back(int'(c.d));
    rec_q.push_back(-1);
    while (rec_q.size() < REC_BYTES - 1) rec_q.push_back(0);
    rec_q.push_back(int'(REC_MARKER));
    m_rec_slot = slot;
    m_idx      = 0;
    exp_we     = 1;
    exp_addr   = slot * REC_BYTES;
    exp_data   = rec_q.pop_front();
  endtask

  // One clock edge of behaviour: what the bus carries during the next cycle.
  task automatic model_step(input bit latch, input cyc_s c, input int rd);
    bit drop = 0, clr = 0, pop = 0, latch_src = 0;
    if (rec_q.size() != 0) begin
      int b;
      b = rec_q.pop_front();
      m_idx++;
      exp_addr = m_rec_slot * REC_BYTES + m_idx;
      if (b < 0) begin
        exp_data = m_drops;
        clr = 1;
      end else begin
        exp_data = b;
      end
    end else if (exp_we) begin
      m_slot = (m_slot + 1) % SLOTS;
      exp_we = 0;
      if (m_pend_v && (m_slot + 1) % SLOTS != rd) begin
        m_start(m_pend, m_slot);
        pop = 1;
      end
    end else if (m_pend_v || latch) begin
      latch_src = !m_pend_v;
      pop       = m_pend_v;
      if ((m_slot + 1) % SLOTS == rd) drop = 1;
      else m_start(m_pend_v ? m_pend : c, m_slot);
    end
    if (latch && !latch_src) begin
      if (!m_pend_v || pop) begin
        m_pend   = c;
        m_pend_v = 1;
      end else begin
        drop = 1;
      end
    end else if (pop) begin
      m_pend_v = 0;
    end
    if (clr) m_drops = drop ? 1 : 0;
    else if (drop && m_drops < 255) m_drops++;
    if (drop) m_ovf = 1;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic cyc_s rand_cyc();
    cyc_s c;
    c.t = cyc_tab[$urandom_range(0, 3)];
    c.a = $urandom;
    c.d = 8'($urandom);
    return c;
  endfunction

  function automatic cyc_s mk(input logic [3:0] t, input logic [31:0] a, input logic [7:0] d);
    cyc_s c;
    c.t = t; c.a = a; c.d = d;
    return c;
  endfunction

  task automatic tick(input bit l, input cyc_s c);
    bus.lpc_latch       = l;
    bus.lpc_cyctype_dir = c.t;
    bus.lpc_addr        = c.a;
    bus.lpc_data        = c.d;
    @(posedge clock);
    model_step(l, c, int'(rd_slot));
    @(negedge clock);
    if (bus.ram_write) shadow[bus.ram_addr] = bus.ram_data;
    check("ram_write", 32'(bus.ram_write), 32'(exp_we));
    check("ram_addr",  32'(bus.ram_addr),  32'(exp_addr));
    check("ram_data",  32'(bus.ram_data),  32'(exp_data));
    check("wr_slot",   32'(wr_slot),       32'(m_slot));
    check("busy",      32'(busy),          32'(exp_we || m_pend_v));
    check("overflow",  32'(overflow),      32'(m_ovf));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, rand_cyc());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_write"}, 32'(bus.ram_write), 32'h0);
    check({tag, "_ram_addr"},  32'(bus.ram_addr),  32'h0);
    check({tag, "_ram_data"},  32'(bus.ram_data),  32'h0);
    check({tag, "_wr_slot"},   32'(wr_slot),       32'h0);
    check({tag, "_busy"},      32'(busy),          32'h0);
    check({tag, "_overflow"},  32'(overflow),      32'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s;
    bus.lpc_latch = 0; bus.lpc_cyctype_dir = '0; bus.lpc_addr = '0; bus.lpc_data = '0;
    rd_slot = '0;
    model_reset();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Single memory write into slot 0.
    tick(1, mk(CYC_MEM_WRITE, 32'hFFFF_FFF0, 8'hA5));
    idle(9);
    for (int k = 0; k < 8; k++) check("single_rec_byte", 32'(shadow[k]), 32'(exp_single[k]));
    check("single_busy_after", 32'(busy), 32'h0);

    // Back-to-back via pending: second strobe three cycles after the first.
    tick(1, mk(CYC_IO_WRITE, 32'h0000_0080, 8'h11));
    idle(2);
    tick(1, mk(CYC_IO_READ, 32'h0000_03F8, 8'h22));
    idle(16);
    check("b2b_slot2_type", 32'(shadow[8'h10]), 32'h00);
    check("b2b_slot2_data", 32'(shadow[8'h15]), 32'h22);

    // Triple burst: third strobe dropped.
    s = m_slot;
    tick(1, mk(CYC_MEM_READ, 32'h1234_5678, 8'h33));
    tick(1, mk(CYC_MEM_WRITE, 32'h9ABC_DEF0, 8'h44));
    tick(1, mk(CYC_IO_WRITE, 32'h0000_0060, 8'h55));
    idle(20);
    check("burst_overflow", 32'(overflow), 32'h1);
    check("burst_drop_rec1", 32'(shadow[s*REC_BYTES + NB + 2]), 32'h01);
    check("burst_drop_rec2", 32'(shadow[((s+1)%SLOTS)*REC_BYTES + NB + 2]), 32'h00);

    // Ring full: fill until wr_slot == SLOTS-1 with the reader parked at 0.
    rd_slot = '0;
    while (m_slot != SLOTS - 1) begin
      tick(1, rand_cyc());
      idle(8);
    end
    check("full_wr_slot", 32'(wr_slot), 32'(SLOTS - 1));
    tick(1, rand_cyc());
    check("full_no_write", 32'(bus.ram_write), 32'h0);
    idle(2);
    rd_slot = SLOT_W'(1);
    tick(1, mk(CYC_MEM_WRITE, 32'hCAFE_F00D, 8'h66));
    idle(9);
    check("wrap_marker", 32'(shadow[8'hFF]), 32'h5A);
    check("wrap_data",   32'(shadow[8'hFD]), 32'h66);
    check("wrap_wr_slot", 32'(wr_slot), 32'h0);

    // Saturation: 300 drops while the ring is full.
    repeat (300) tick(1, rand_cyc());
    rd_slot = SLOT_W'(2);
    tick(1, rand_cyc());
    idle(9);
    check("sat_drop_byte", 32'(shadow[NB + 2]), 32'hFF);

    // Randomized traffic at several strobe densities.
    for (int i = 0; i < 1500; i++) begin
      int pct;
      pct = (i < 500) ? 15 : (i < 1000) ? 50 : 95;
      if (i % 64 == 0)
        rd_slot = ($urandom_range(0, 1) == 1) ? SLOT_W'((m_slot + 2) % SLOTS)
                                              : SLOT_W'($urandom_range(0, SLOTS - 1));
      tick($urandom_range(0, 99) < pct, rand_cyc());
    end
    idle(20);

    // Reset in the middle of a record.
    rd_slot = SLOT_W'((m_slot + 10) % SLOTS);
    tick(1, rand_cyc());
    idle(3);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    rd_slot = '0;
    tick(1, mk(CYC_MEM_READ, 32'h0BAD_BEEF, 8'h77));
    check("midrst_restart_addr", 32'(bus.ram_addr), 32'h0);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
